uart_rx_channel: RTL and testbench
==================================

Name: uart_rx_channel

Overview:
Per-interface UART receiver that sits directly upstream of the MITM logic stage. It oversamples one bus RX line and deserialises 8N1 frames, LSB first. Each completed byte is presented as recv_data with a one-cycle new_data_ready strobe, which drives the ifN_recv_new_data_ready / real_ifN_recv_data inputs of the MITM stage. One instance is used per intercepted interface.

Parameters:
CLKS_PER_BIT, 1250, sys_clk cycles per bit period (12 MHz / 9600 baud); must be >= 4.
NUM_DATA_BITS, 8, data bits per frame.
SYNC_STAGES, 2, flip-flops in the rx_in synchroniser chain; must be >= 2.

Ports:
sys_clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  asynchronous, active-low reset.
rx_in  input  1  raw asynchronous serial line; idle level is high.
recv_data  output  NUM_DATA_BITS  last good byte; holds its value between frames.
new_data_ready  output  1  one-cycle strobe; recv_data is valid on that cycle and after it.
recv_busy  output  1  high whenever the FSM is not in IDLE.
frame_error  output  1  one-cycle strobe when the stop bit is sampled low.
parity_error  output  1  one-cycle strobe on parity mismatch; tied to 0 when the optional feature is compiled out.

Behaviour:
- Reset (rst=0, asynchronous): every output is driven to 0, except recv_data which resets to all-zeros. The synchroniser resets to all-ones (line idle). FSM goes to IDLE and all counters clear. Releasing reset mid-frame discards the partial frame.
- rx_s is the last synchroniser stage. It lags rx_in by SYNC_STAGES cycles.
- Counters: bit_cnt is 0..CLKS_PER_BIT-1 and wraps. bit_idx is 0..NUM_DATA_BITS-1. Widths come from $clog2.
- IDLE: when rx_s==0, go to START and clear bit_cnt.
- START: count to CLKS_PER_BIT/2-1 (mid start bit).
  - If rx_s==0, go to DATA and clear bit_cnt and bit_idx.
  - If rx_s==1, treat it as a glitch: return to IDLE with no strobe.
- DATA: on each bit_cnt==CLKS_PER_BIT-1, shift rx_s into a shift register LSB first.
  - After bit NUM_DATA_BITS-1, go to PARITY if the optional feature is enabled, otherwise go to STOP.
- STOP: at bit_cnt==CLKS_PER_BIT-1, sample rx_s.
  - If 1: load recv_data from the shift register, pulse new_data_ready, go to IDLE.
  - If 0: pulse frame_error, leave recv_data unchanged, go to BREAK.
- BREAK: stay until rx_s==1, then go to IDLE. This covers break conditions and a held-low line.
- Latency: new_data_ready rises exactly SYNC_STAGES + CLKS_PER_BIT/2 + (NUM_DATA_BITS+1)*CLKS_PER_BIT + 1 cycles after the first sys_clk edge that samples rx_in low (no parity).
- Strobes are registered outputs, high for exactly one cycle. At most one strobe is asserted per frame.
- Back-to-back frames: a start bit that begins right after the stop-bit mid-sample is accepted. IDLE re-arms on the cycle after the strobe, so there is no dead time beyond half a bit.
- recv_busy is combinational from the FSM state register, i.e. (state != IDLE).
- Undefined state encodings recover to IDLE with no strobe.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - Adds a PARITY state between DATA and STOP that samples one even-parity bit at bit_cnt==CLKS_PER_BIT-1.
  - In STOP, a good stop bit with a parity mismatch pulses parity_error instead of new_data_ready and leaves recv_data unchanged.
  - A bad stop bit always reports frame_error, with priority over parity_error.
  - Latency grows by CLKS_PER_BIT.
- Undefined:
  - No PARITY state exists; frames are 8N1.
  - parity_error is a constant 0.

Test Plan:
1. CLKS_PER_BIT=16, send 0x24 as 8N1 -> new_data_ready high exactly 1 cycle, 2+8+144+1=155 cycles after the rx_in falling edge; recv_data==0x24; frame_error stays 0.
2. Send 0x41 then 0x5A back-to-back with no idle gap -> two strobes, 160 cycles apart; recv_data reads 0x41 then 0x5A.
3. rx_in low pulse of 5 cycles (shorter than half a bit) -> no strobe; recv_busy returns to 0 within 10 cycles; a following 0x23 frame is received correctly.
4. Send 0x55 with the stop bit forced low and the line then held low for 40 cycles -> frame_error pulses once; recv_data keeps its previous value; no new frame starts until rx_in returns high.
5. Assert rst low mid-way through the data bits of 0x7E -> all outputs are 0 immediately (asynchronous); after release and line idle, the next 0x31 frame is received correctly.
6. With UART_RX_PARITY_EN defined, send 0x03 with parity bit 1 -> parity_error strobe, no new_data_ready; resend with parity bit 0 -> recv_data==0x03.

Source files
------------

// File: rtl/uart_rx_channel.sv
// ---------------------------------------------------------------------------
// uart_rx_channel
//
// Per-interface UART receiver placed in front of the MITM logic stage.
// The block synchronises one asynchronous RX line and oversamples it. It
// deserialises frames LSB first and hands each good byte downstream as
// recv_data, together with a one-cycle new_data_ready strobe.
//
// Optional feature macro: UART_RX_PARITY_EN
//   undefined : 8N1 frames, parity_error is a constant 0
//   defined   : 8E1 frames, one even-parity bit between data and stop
//
// Ports
//   sys_clk        in   system clock, rising edge
//   rst            in   asynchronous active-low reset
//   rx_in          in   raw serial line, idle high
//   recv_data      out  last good byte, held between frames
//   new_data_ready out  one-cycle strobe, recv_data valid from this cycle on
//   recv_busy      out  high whenever the receiver is not idle
//   frame_error    out  one-cycle strobe, stop bit sampled low
//   parity_error   out  one-cycle strobe, parity mismatch (parity builds)
// ---------------------------------------------------------------------------
module uart_rx_channel #(
  parameter int CLKS_PER_BIT  = 1250,
  parameter int NUM_DATA_BITS = 8,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     rx_in,
  output logic [NUM_DATA_BITS-1:0] recv_data,
  output logic                     new_data_ready,
  output logic                     recv_busy,
  output logic                     frame_error,
  output logic                     parity_error
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (NUM_DATA_BITS > 1) ? $clog2(NUM_DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     rx_s;
  logic [CNT_W-1:0]         bit_cnt;
  logic [IDX_W-1:0]         bit_idx;
  logic [NUM_DATA_BITS-1:0] shift_reg;

  logic cnt_done;
  logic half_done;
  logic last_bit;
  logic cnt_clear;
  logic cnt_run;
  logic idx_clear;
  logic shift_en;
  logic ndr_d;
  logic fe_d;

`ifdef UART_RX_PARITY_EN
  logic par_q;
  logic par_sample;
  logic par_bad;
  logic pe_d;
`endif

  // Synchroniser chain. It resets to all-ones so that reset looks like an
  // idle line and never produces a false start bit.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
    end
  end

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign cnt_done  = (bit_cnt == CNT_LAST);
  assign half_done = (bit_cnt == CNT_HALF);
  assign last_bit  = (bit_idx == IDX_LAST);
  assign recv_busy = (state != IDLE);

`ifdef UART_RX_PARITY_EN
  // Even parity: the received parity bit must equal the XOR of the data bits.
  assign par_bad = (par_q != (^shift_reg));
`endif

  // State register
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Encodings that fall through to the default recover
  // to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!rx_s) state_next = START;
      end
      START: begin
        if (half_done) state_next = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (cnt_done && last_bit) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_done) state_next = STOP;
      end
`endif
      STOP: begin
        if (cnt_done) state_next = rx_s ? IDLE : BREAK;
      end
      BREAK: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output and datapath control. The STOP decision is the only place a
  // strobe is requested, so each frame ends with at most one strobe.
  always_comb begin
    cnt_clear = 1'b0;
    cnt_run   = 1'b0;
    idx_clear = 1'b0;
    shift_en  = 1'b0;
    ndr_d     = 1'b0;
    fe_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_sample = 1'b0;
    pe_d       = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_clear = 1'b1;
      end
      START: begin
        cnt_run = 1'b1;
        if (half_done && !rx_s) begin
          cnt_clear = 1'b1;
          idx_clear = 1'b1;
        end
      end
      DATA: begin
        cnt_run  = 1'b1;
        shift_en = cnt_done;
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        cnt_run    = 1'b1;
        par_sample = cnt_done;
      end
`endif
      STOP: begin
        cnt_run = 1'b1;
        if (cnt_done) begin
          if (!rx_s) fe_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          else if (par_bad) pe_d = 1'b1;
`endif
          else ndr_d = 1'b1;
        end
      end
      default: begin
        cnt_clear = 1'b1;
      end
    endcase
  end

  // Bit-period counter. It wraps at CLKS_PER_BIT-1, so in DATA, PARITY and
  // STOP every wrap lands on the middle of the next bit. START has already
  // moved the phase to the middle of the start bit.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
    end else if (cnt_clear) begin
      bit_cnt <= '0;
    end else if (cnt_run) begin
      bit_cnt <= cnt_done ? '0 : bit_cnt + 1'b1;
    end
  end

  // Data bit index and LSB-first shift register
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      bit_idx   <= '0;
      shift_reg <= '0;
    end else if (idx_clear) begin
      bit_idx <= '0;
    end else if (shift_en) begin
      bit_idx   <= last_bit ? '0 : bit_idx + 1'b1;
      shift_reg <= {rx_s, shift_reg[NUM_DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  // Captured parity bit, compared against the data in STOP
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      par_q <= 1'b0;
    end else if (par_sample) begin
      par_q <= rx_s;
    end
  end
`endif

  // Registered outputs. recv_data loads only on a good frame, so error
  // frames leave the previous byte in place.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      recv_data      <= '0;
      new_data_ready <= 1'b0;
      frame_error    <= 1'b0;
    end else begin
      new_data_ready <= ndr_d;
      frame_error    <= fe_d;
      if (ndr_d) recv_data <= shift_reg;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      parity_error <= 1'b0;
    end else begin
      parity_error <= pe_d;
    end
  end
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_channel.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_channel
//
// Self-checking bench for uart_rx_channel with CLKS_PER_BIT=16. A driver
// serialises whole frames onto rx_in. A monitor collects every strobe that
// the receiver raises. The expected bytes come from a plain queue of the
// bytes sent as good frames. Honours UART_RX_PARITY_EN like the design.
// ---------------------------------------------------------------------------
module tb_uart_rx_channel;

  localparam int CPB    = 16;
  localparam int NBITS  = 8;
  localparam int PERIOD = 10;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Cycles from the rx_in falling edge to the negedge that sees the strobe
  localparam int LATENCY = 2 + CPB / 2 + (FRAME_BITS - 1) * CPB + 1;

  logic             sys_clk;
  logic             rst;
  logic             rx_in;
  logic [NBITS-1:0] recv_data;
  logic             new_data_ready;
  logic             recv_busy;
  logic             frame_error;
  logic             parity_error;

  int checks = 0;
  int errors = 0;

  logic [NBITS-1:0] got_q[$];
  time              got_t_q[$];
  logic [NBITS-1:0] model_q[$];
  int               fe_cnt = 0;
  int               pe_cnt = 0;
  time              last_fall;

  uart_rx_channel #(
    .CLKS_PER_BIT (CPB),
    .NUM_DATA_BITS(NBITS),
    .SYNC_STAGES  (2)
  ) dut (
    .sys_clk       (sys_clk),
    .rst           (rst),
    .rx_in         (rx_in),
    .recv_data     (recv_data),
    .new_data_ready(new_data_ready),
    .recv_busy     (recv_busy),
    .frame_error   (frame_error),
    .parity_error  (parity_error)
  );

  // Free-running clock: rising edges at 5, 15, 25 ... ns
  initial sys_clk = 1'b0;
  always #(PERIOD / 2) sys_clk = ~sys_clk;

  // Monitor: samples outputs on the falling edge and records every strobe
  // cycle. A strobe held for two cycles shows up as two received bytes.
  always @(negedge sys_clk) begin
    if (new_data_ready) begin
      got_q.push_back(recv_data);
      got_t_q.push_back($time);
    end
    if (frame_error) fe_cnt++;
    if (parity_error) pe_cnt++;
  end

  // Watchdog so a stuck run still terminates
  initial begin
    #(200000 * PERIOD);
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_line(input int cycles);
    rx_in = 1'b1;
    repeat (cycles) @(negedge sys_clk);
  endtask

  // Serialises one frame, starting on a falling edge and ending on one. The
  // line is left at the stop-bit level.
  task automatic send_frame(input logic [NBITS-1:0] data, input logic stop_bit,
                            input logic par_bit);
    logic frame[FRAME_BITS];
    frame[0] = 1'b0;
    for (int i = 0; i < NBITS; i++) frame[1 + i] = data[i];
`ifdef UART_RX_PARITY_EN
    frame[NBITS + 1] = par_bit;
`else
    if (par_bit !== ^data) $display("[TB] note: parity bit ignored in 8N1 build");
`endif
    frame[FRAME_BITS - 1] = stop_bit;
    for (int i = 0; i < FRAME_BITS; i++) begin
      rx_in = frame[i];
      if (i == 0) last_fall = $time;
      repeat (CPB) @(negedge sys_clk);
    end
  endtask

  // Good frame: the model expects this byte to come out unchanged
  task automatic apply_stimulus(input logic [NBITS-1:0] data);
    model_q.push_back(data);
    send_frame(data, 1'b1, ^data);
  endtask

  // Compares one received byte and its latency against the model
  task automatic check_received(input string tag);
    logic [NBITS-1:0] exp_b;
    check_output({tag, "_count"}, got_q.size(), 1);
    if (got_q.size() > 0 && model_q.size() > 0) begin
      exp_b = model_q.pop_front();
      check_output({tag, "_data"}, got_q.pop_front(), exp_b);
      check_output({tag, "_latency"}, int'((got_t_q.pop_front() - last_fall) / PERIOD), LATENCY);
    end
    got_q.delete();
    got_t_q.delete();
    model_q.delete();
  endtask

  task automatic wait_not_busy(input int limit);
    int waited;
    waited = 0;
    while (recv_busy && waited < limit) begin
      @(negedge sys_clk);
      waited++;
    end
  endtask

  // Directed sequence followed by a short randomized run
  initial begin
    logic [NBITS-1:0] b;
    time              t_first;
    int               fe_before;

    rx_in = 1'b1;
    rst   = 1'b0;
    repeat (3) @(negedge sys_clk);

    check_output("reset_recv_data", recv_data, 8'h00);
    check_output("reset_ndr", new_data_ready, 1'b0);
    check_output("reset_busy", recv_busy, 1'b0);
    check_output("reset_frame_error", frame_error, 1'b0);
    check_output("reset_parity_error", parity_error, 1'b0);

    rst = 1'b1;
    idle_line(10);

    $display("[TB] single frame 0x24");
    apply_stimulus(8'h24);
    idle_line(4);
    check_received("frame_24");
    check_output("frame_24_no_fe", fe_cnt, 0);

    $display("[TB] back-to-back 0x41, 0x5A");
    apply_stimulus(8'h41);
    t_first = last_fall;
    apply_stimulus(8'h5A);
    idle_line(4);
    check_output("b2b_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check_output("b2b_gap", int'((got_t_q[1] - got_t_q[0]) / PERIOD), FRAME_BITS * CPB);
      check_output("b2b_first", got_q[0], 8'h41);
      check_output("b2b_second", got_q[1], 8'h5A);
      check_output("b2b_first_latency", int'((got_t_q[0] - t_first) / PERIOD), LATENCY);
    end
    got_q.delete();
    got_t_q.delete();
    model_q.delete();

    $display("[TB] short low glitch");
    rx_in = 1'b0;
    repeat (5) @(negedge sys_clk);
    rx_in = 1'b1;
    check_output("glitch_busy_seen", recv_busy, 1'b1);
    wait_not_busy(10);
    check_output("glitch_busy_clear", recv_busy, 1'b0);
    idle_line(20);
    check_output("glitch_no_strobe", got_q.size(), 0);
    check_output("glitch_no_fe", fe_cnt, 0);
    apply_stimulus(8'h23);
    idle_line(4);
    check_received("after_glitch_23");

    $display("[TB] bad stop bit then held-low line");
    fe_before = fe_cnt;
    send_frame(8'h55, 1'b0, ^(8'h55));
    repeat (40) @(negedge sys_clk);
    check_output("break_fe_once", fe_cnt - fe_before, 1);
    check_output("break_no_strobe", got_q.size(), 0);
    check_output("break_data_kept", recv_data, 8'h23);
    check_output("break_busy_held", recv_busy, 1'b1);
    rx_in = 1'b1;
    wait_not_busy(10);
    check_output("break_busy_clear", recv_busy, 1'b0);
    idle_line(30);
    check_output("break_no_restart", got_q.size(), 0);
    check_output("break_fe_total", fe_cnt - fe_before, 1);

    $display("[TB] reset mid-frame");
    b = 8'h7E;
    rx_in = 1'b0;
    repeat (CPB) @(negedge sys_clk);
    for (int i = 0; i < 4; i++) begin
      rx_in = b[i];
      repeat (CPB) @(negedge sys_clk);
    end
    check_output("midreset_busy_before", recv_busy, 1'b1);
    #3 rst = 1'b0;
    #1;
    check_output("midreset_recv_data", recv_data, 8'h00);
    check_output("midreset_busy", recv_busy, 1'b0);
    check_output("midreset_ndr", new_data_ready, 1'b0);
    check_output("midreset_fe", frame_error, 1'b0);
    rx_in = 1'b1;
    @(negedge sys_clk);
    repeat (4) @(negedge sys_clk);
    rst = 1'b1;
    idle_line(20);
    check_output("midreset_no_strobe", got_q.size(), 0);
    apply_stimulus(8'h31);
    idle_line(4);
    check_received("after_reset_31");

`ifdef UART_RX_PARITY_EN
    $display("[TB] parity mismatch then good parity");
    send_frame(8'h03, 1'b1, 1'b1);
    idle_line(4);
    check_output("parity_bad_pe", pe_cnt, 1);
    check_output("parity_bad_no_strobe", got_q.size(), 0);
    check_output("parity_bad_data_kept", recv_data, 8'h31);
    model_q.push_back(8'h03);
    send_frame(8'h03, 1'b1, 1'b0);
    idle_line(4);
    check_received("parity_good_03");
    check_output("parity_pe_total", pe_cnt, 1);
`endif

    $display("[TB] randomized frames");
    for (int k = 0; k < 6; k++) begin
      b = NBITS'($urandom_range(0, 255));
      idle_line($urandom_range(0, 12));
      apply_stimulus(b);
      idle_line(4);
      check_received($sformatf("random_%0d", k));
    end

`ifndef UART_RX_PARITY_EN
    check_output("parity_error_never", pe_cnt, 0);
`endif
    check_output("final_fe_total", fe_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
